// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS-subset control unit: state register plus Moore decode of every
// datapath select and memory request, driven from the instruction register.
module mcpu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_ready,
    input  logic [31:0] Inst,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
        S_LWB = 4'd4,  S_MW  = 4'd5,  S_RX  = 4'd6,  S_RWB = 4'd7,
        S_BR  = 4'd8,  S_JMP = 4'd9,  S_IX  = 4'd10, S_IWB = 4'd11,
        S_LUI = 4'd12, S_JR  = 4'd13, S_JAL = 4'd14
    } state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e     state_q;
    state_e     cur_s;
    state_e     id_next;
    logic       id_illegal;
    logic [2:0] rx_alu;
    logic       rx_ok;
    logic [2:0] ix_alu;
    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_inst;

    assign op          = Inst[31:26];
    assign fn          = Inst[5:0];
    assign unused_inst = ^Inst[25:6];

    // While reset is low the outputs already show the fetch decode.
    assign cur_s = reset ? state_q : S_IF;

    // R-type funct and I-type opcode to ALU operation.
    always_comb begin
        rx_alu = ALU_ADD;
        rx_ok  = 1'b1;
        case (fn)
            6'b100000: rx_alu = ALU_ADD;
            6'b100010: rx_alu = ALU_SUB;
            6'b100100: rx_alu = ALU_AND;
            6'b100101: rx_alu = ALU_OR;
            6'b100110: rx_alu = ALU_XOR;
            6'b100111: rx_alu = ALU_NOR;
            6'b101010: rx_alu = ALU_SLT;
            6'b000010: rx_alu = ALU_SRL;
            default:   rx_ok  = 1'b0;
        endcase
        ix_alu = ALU_ADD;
        case (op)
            OP_ANDI: ix_alu = ALU_AND;
            OP_ORI:  ix_alu = ALU_OR;
            OP_XORI: ix_alu = ALU_XOR;
            OP_SLTI: ix_alu = ALU_SLT;
            default: ix_alu = ALU_ADD;
        endcase
    end

    // Dispatch target out of ID; unsupported encodings fall back to fetch.
    always_comb begin
        id_next    = S_IF;
        id_illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR)  id_next = S_JR;
                else if (rx_ok)   id_next = S_RX;
                else              id_illegal = 1'b1;
            end
            OP_LW, OP_SW:                             id_next = S_MA;
            OP_BEQ, OP_BNE:                           id_next = S_BR;
            OP_J:                                     id_next = S_JMP;
            OP_JAL:                                   id_next = S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: id_next = S_IX;
            OP_LUI:                                   id_next = S_LUI;
            default:                                  id_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    state_q <= MIO_ready ? S_ID : S_IF;
                S_ID:    state_q <= id_next;
                S_MA:    state_q <= (op == OP_LW) ? S_MR : S_MW;
                S_MR:    state_q <= MIO_ready ? S_LWB : S_MR;
                S_MW:    state_q <= MIO_ready ? S_IF : S_MW;
                S_RX:    state_q <= S_RWB;
                S_IX:    state_q <= S_IWB;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Moore decode of the current state.
    always_comb begin
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = ALU_ADD;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        illegal       = 1'b0;
        case (cur_s)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                illegal = id_illegal;
            end
            S_MA: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MR: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_LWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MW: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_RX: begin
                ALUSrcA       = 2'b01;
                ALU_operation = rx_alu;
            end
            S_RWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_BR: begin
                ALUSrcA       = 2'b01;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                Branch        = (op == OP_BEQ);
            end
            S_JMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_IX: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b10;
                ALU_operation = ix_alu;
            end
            S_IWB: RegWrite = 1'b1;
            S_LUI: begin
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                ALUSrcA = 2'b01;
                PCWrite = 1'b1;
            end
            S_JAL: begin
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                RegWrite = 1'b1;
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign CPU_MIO = MemRead | MemWrite;
    assign state   = cur_s;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Randomized bench for mcpu_ctrl: an instruction-level model predicts the state walk
// and the full control vector of every cycle, including memory stalls and resets.
module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MIO_ready;
    logic [31:0] Inst;
    logic        IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [3:0]  state;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;
    logic rw_prev = 1'b0;

    always #5 clk = ~clk;

    mcpu_ctrl dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation), .MemRead(MemRead),
        .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .state(state), .illegal(illegal)
    );

    typedef enum int { K_LW, K_SW, K_R, K_JR, K_BEQ, K_BNE, K_J, K_JAL, K_IX, K_LUI, K_ILL } kind_e;

    typedef struct packed {
        logic       iord, irwrite, regwrite, pcwrite, pcwritecond, branch;
        logic [1:0] regdst, memtoreg, alusrca, alusrcb, pcsource;
        logic [2:0] alu;
        logic       memread, memwrite, cpu_mio, illegal;
    } ctrl_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_JR;
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02}) return K_R;
            return K_ILL;
        end
        case (op)
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: return K_IX;
            6'h0F: return K_LUI;
            default: return K_ILL;
        endcase
    endfunction

    // Operation the ALU must perform, named by mnemonic then encoded.
    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        string m;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: m = "add"; 6'h22: m = "sub"; 6'h24: m = "and"; 6'h25: m = "or";
                6'h26: m = "xor"; 6'h27: m = "nor"; 6'h2A: m = "slt"; default: m = "srl";
            endcase
        end else begin
            case (ins[31:26])
                6'h0C: m = "and"; 6'h0D: m = "or"; 6'h0E: m = "xor"; 6'h0A: m = "slt";
                default: m = "add";
            endcase
        end
        case (m)
            "and": return 3'd0; "or":  return 3'd1; "add": return 3'd2; "xor": return 3'd3;
            "nor": return 3'd4; "srl": return 3'd5; "sub": return 3'd6; default: return 3'd7;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input int st, input logic [31:0] ins, input logic rdy);
        ctrl_t c = '0;
        c.alu = 3'd2;
        case (st)
            0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            1:  begin c.alusrcb = 2'b11; c.illegal = (classify(ins) == K_ILL); end
            2:  begin c.alusrca = 2'b01; c.alusrcb = 2'b10; end
            3:  begin c.iord = 1; c.memread = 1; end
            4:  begin c.memtoreg = 2'b01; c.regwrite = 1; end
            5:  begin c.iord = 1; c.memwrite = 1; end
            6:  begin c.alusrca = 2'b01; c.alu = alu_of(ins); end
            7:  begin c.regdst = 2'b01; c.regwrite = 1; end
            8:  begin c.alusrca = 2'b01; c.alu = 3'd6; c.pcwritecond = 1; c.pcsource = 2'b01;
                      c.branch = (classify(ins) == K_BEQ); end
            9:  begin c.pcsource = 2'b10; c.pcwrite = 1; end
            10: begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.alu = alu_of(ins); end
            11: c.regwrite = 1;
            12: begin c.memtoreg = 2'b10; c.regwrite = 1; end
            13: begin c.alusrca = 2'b01; c.pcwrite = 1; end
            14: begin c.regdst = 2'b10; c.memtoreg = 2'b11; c.regwrite = 1;
                      c.pcsource = 2'b10; c.pcwrite = 1; end
            default: ;
        endcase
        c.cpu_mio = c.memread | c.memwrite;
        return c;
    endfunction

    // One clock: drive inputs just after the edge, check mid-cycle, advance.
    task automatic cyc(input int est, input logic [31:0] ins, input logic rdy,
                       input logic rst_n, input string tag);
        ctrl_t obs;
        reset     = rst_n;
        Inst      = ins;
        MIO_ready = rdy;
        #3;
        obs = {IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, PCSource, ALU_operation, MemRead, MemWrite, CPU_MIO, illegal};
        check_eq($sformatf("%s state", tag), 32'(state), 32'(est));
        check_eq($sformatf("%s st%0d ctrl", tag, est), 32'(obs), 32'(exp_ctrl(est, ins, rdy)));
        check_eq($sformatf("%s regwrite_back_to_back", tag), 32'(rw_prev & RegWrite), 32'd0);
        rw_prev = RegWrite;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through its expected walk; optional reset during the memory wait.
    task automatic run_instr(input logic [31:0] ins, input int if_wait, input int mem_wait,
                             input bit abort_mem, input string tag);
        int st_q[$];
        bit rdy_q[$];
        kind_e k = classify(ins);
        for (int i = 0; i < if_wait; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom));
        case (k)
            K_LW, K_SW: begin
                int ms = (k == K_LW) ? 3 : 5;
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < mem_wait; i++) begin st_q.push_back(ms); rdy_q.push_back(1'b0); end
                st_q.push_back(ms); rdy_q.push_back(1'b1);
                if (k == K_LW) begin st_q.push_back(4); rdy_q.push_back(1'($urandom)); end
            end
            K_R:   begin st_q.push_back(6);  st_q.push_back(7);  rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom)); end
            K_IX:  begin st_q.push_back(10); st_q.push_back(11); rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom)); end
            K_BEQ, K_BNE: begin st_q.push_back(8);  rdy_q.push_back(1'($urandom)); end
            K_J:   begin st_q.push_back(9);  rdy_q.push_back(1'($urandom)); end
            K_JAL: begin st_q.push_back(14); rdy_q.push_back(1'($urandom)); end
            K_JR:  begin st_q.push_back(13); rdy_q.push_back(1'($urandom)); end
            K_LUI: begin st_q.push_back(12); rdy_q.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            logic [31:0] drive = (st_q[i] == 0) ? $urandom : ins;
            if (abort_mem && (st_q[i] == 3 || st_q[i] == 5)) begin
                cyc(0, ins, 1'b0, 1'b0, {tag, " rst_in_mem"});
                cyc(0, ins, 1'b0, 1'b1, {tag, " after_rst"});
                return;
            end
            cyc(st_q[i], drive, rdy_q[i], 1'b1, tag);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops_i[10] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0F, 6'h0A};
        logic [5:0]  fns[10]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08, 6'h21};
        logic [5:0]  bad[6]    = '{6'h01, 6'h06, 6'h07, 6'h09, 6'h20, 6'h3F};
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 9)]; end
            3:       r[31:26] = bad[$urandom_range(0, 5)];
            4:       r[31:26] = ($urandom_range(0, 1) == 0) ? 6'h0D : 6'h0E;
            default: r[31:26] = ops_i[$urandom_range(0, 9)];
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b0;
        MIO_ready = 1'b1;
        Inst = 32'h0;
        #1;
        for (int i = 0; i < 3; i++) cyc(0, $urandom, 1'b1, 1'b0, "reset_hold");
        run_instr(32'h8C430004, 0, 2, 1'b0, "lw_stall");
        run_instr(32'h00430820, 0, 0, 1'b0, "add");
        run_instr(32'h00430822, 0, 0, 1'b0, "sub");
        run_instr(32'h10430003, 1, 0, 1'b0, "beq");
        run_instr(32'h14430003, 0, 0, 1'b0, "bne");
        run_instr(32'h0C000010, 0, 0, 1'b0, "jal");
        run_instr(32'hFC000000, 0, 0, 1'b0, "illegal");
        run_instr(32'hAC430004, 0, 3, 1'b1, "sw_abort");
        run_instr(32'hAC430004, 2, 1, 1'b0, "sw");
        run_instr(32'h03E00008, 0, 0, 1'b0, "jr");
        run_instr(32'h3C011234, 0, 0, 1'b0, "lui");
        for (int n = 0; n < 400; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0), $sformatf("rnd%0d", n));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
